// File: rtl/px.sv
// px: major-state sequencer with STROB1/STROB2/GOT timing generator.
// Holds the one-hot processor state and walks a per-state phase FSM, including memory waits.
module px #(
    parameter int S1_TICKS   = 3,
    parameter int S2_TICKS   = 3,
    parameter int GAP_TICKS  = 2,
    parameter int OK_TIMEOUT = 64
) (
    input  logic __clk,
    input  logic clo,
    input  logic ep0,
    input  logic ep1,
    input  logic ep2,
    input  logic ep3,
    input  logic ep4,
    input  logic ep5,
    input  logic ek1,
    input  logic ek2,
    input  logic ei1,
    input  logic ei2,
    input  logic ei3,
    input  logic ei4,
    input  logic ei5,
    input  logic ewx,
    input  logic ok,
    output logic p0_,
    output logic p1_,
    output logic p2_,
    output logic p3_,
    output logic p4_,
    output logic p5_,
    output logic k1_,
    output logic k2_,
    output logic i1_,
    output logic i2_,
    output logic i3_,
    output logic i4_,
    output logic i5_,
    output logic wx_,
    output logic strob1_,
    output logic strob2_,
    output logic got_,
    output logic mem_req,
    output logic alarm
);

    // State bits are ordered by GOT priority, so the lowest set request bit wins.
    localparam int IX_K2  = 0;
    localparam int IX_K1  = 1;
    localparam int IX_P0  = 2;
    localparam int IX_I1  = 3;
    localparam int IX_I2  = 4;
    localparam int IX_I3  = 5;
    localparam int IX_I4  = 6;
    localparam int IX_I5  = 7;
    localparam int IX_P1  = 8;
    localparam int IX_P2  = 9;
    localparam int IX_P3  = 10;
    localparam int IX_P4  = 11;
    localparam int IX_P5  = 12;
    localparam int IX_WX  = 13;
    localparam int NUM_ST = 14;

    localparam logic [NUM_ST-1:0] TWO_MASK =
        (NUM_ST'(1) << IX_P1) | (NUM_ST'(1) << IX_P3) | (NUM_ST'(1) << IX_P4) |
        (NUM_ST'(1) << IX_K2) | (NUM_ST'(1) << IX_I2) | (NUM_ST'(1) << IX_WX);
    localparam logic [NUM_ST-1:0] MEM_MASK =
        (NUM_ST'(1) << IX_P1) | (NUM_ST'(1) << IX_P2) | (NUM_ST'(1) << IX_I2) |
        (NUM_ST'(1) << IX_I3) | (NUM_ST'(1) << IX_I4) | (NUM_ST'(1) << IX_I5);
    localparam logic [NUM_ST-1:0] RESET_ST = NUM_ST'(1) << IX_P0;

    localparam int MAX_T1 = (S1_TICKS > S2_TICKS) ? S1_TICKS : S2_TICKS;
    localparam int MAX_T2 = (MAX_T1 > GAP_TICKS) ? MAX_T1 : GAP_TICKS;
    localparam int MAX_T  = (MAX_T2 > OK_TIMEOUT) ? MAX_T2 : OK_TIMEOUT;
    localparam int CW     = $clog2(MAX_T + 1);

    localparam logic [CW-1:0] S1_LAST  = CW'(S1_TICKS - 1);
    localparam logic [CW-1:0] S2_LAST  = CW'(S2_TICKS - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(OK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        PH_S1,
        PH_G1,
        PH_MW,
        PH_S2,
        PH_G2,
        PH_GOT
    } phase_e;

    phase_e              phase_q, phase_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [NUM_ST-1:0]   state_q, state_d;
    logic                run_q, run_d;
    logic                alarm_q, alarm_d;
    logic                strob1_q, strob1_d;
    logic                strob2_q, strob2_d;
    logic                got_q, got_d;
    logic                mem_req_q, mem_req_d;

    logic [NUM_ST-1:0]   req;
    logic [NUM_ST-1:0]   pick;
    logic                is_two;
    logic                is_mem;

    assign req = {ewx, ep5, ep4, ep3, ep2, ep1, ei5, ei4, ei3, ei2, ei1, ep0, ek1, ek2};

    assign is_two = |(state_q & TWO_MASK);
    assign is_mem = |(state_q & MEM_MASK);

    // Scanning from the top down leaves the highest-priority request in pick.
    always_comb begin
        pick = state_q;
        for (int i = NUM_ST - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick    = '0;
                pick[i] = 1'b1;
            end
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q + CW'(1);
        state_d = state_q;
        alarm_d = alarm_q;
        run_d   = 1'b1;

        if (!run_q) begin
            // First edge after reset opens S1 with a fresh count.
            phase_d = PH_S1;
            cnt_d   = '0;
        end else begin
            unique case (phase_q)
                PH_S1: begin
                    if (cnt_q == S1_LAST) begin
                        phase_d = PH_G1;
                        cnt_d   = '0;
                    end
                end
                PH_G1: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_d = '0;
                        if (is_mem)      phase_d = PH_MW;
                        else if (is_two) phase_d = PH_S2;
                        else             phase_d = PH_GOT;
                    end
                end
                PH_MW: begin
                    if (ok || cnt_q == TO_LAST) begin
                        cnt_d   = '0;
                        phase_d = is_two ? PH_S2 : PH_GOT;
                        if (!ok) alarm_d = 1'b1;
                    end
                end
                PH_S2: begin
                    if (cnt_q == S2_LAST) begin
                        phase_d = PH_G2;
                        cnt_d   = '0;
                    end
                end
                PH_G2: begin
                    if (cnt_q == GAP_LAST) begin
                        phase_d = PH_GOT;
                        cnt_d   = '0;
                    end
                end
                PH_GOT: begin
                    phase_d = PH_S1;
                    cnt_d   = '0;
                    state_d = pick;
                end
                default: begin
                    phase_d = PH_S1;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Pulse outputs are decoded from the next phase and registered, so they are glitch-free.
    always_comb begin
        strob1_d  = !(run_d && phase_d == PH_S1);
        strob2_d  = !(phase_d == PH_S2);
        got_d     = !(phase_d == PH_GOT);
        mem_req_d = (phase_d == PH_MW);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge __clk or posedge clo) begin
        if (clo) begin
            phase_q   <= PH_S1;
            cnt_q     <= '0;
            state_q   <= RESET_ST;
            run_q     <= 1'b0;
            alarm_q   <= 1'b0;
            strob1_q  <= 1'b1;
            strob2_q  <= 1'b1;
            got_q     <= 1'b1;
            mem_req_q <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            run_q     <= run_d;
            alarm_q   <= alarm_d;
            strob1_q  <= strob1_d;
            strob2_q  <= strob2_d;
            got_q     <= got_d;
            mem_req_q <= mem_req_d;
        end
    end

    assign k2_ = ~state_q[IX_K2];
    assign k1_ = ~state_q[IX_K1];
    assign p0_ = ~state_q[IX_P0];
    assign i1_ = ~state_q[IX_I1];
    assign i2_ = ~state_q[IX_I2];
    assign i3_ = ~state_q[IX_I3];
    assign i4_ = ~state_q[IX_I4];
    assign i5_ = ~state_q[IX_I5];
    assign p1_ = ~state_q[IX_P1];
    assign p2_ = ~state_q[IX_P2];
    assign p3_ = ~state_q[IX_P3];
    assign p4_ = ~state_q[IX_P4];
    assign p5_ = ~state_q[IX_P5];
    assign wx_ = ~state_q[IX_WX];

    assign strob1_ = strob1_q;
    assign strob2_ = strob2_q;
    assign got_    = got_q;
    assign mem_req = mem_req_q;
    assign alarm   = alarm_q;

endmodule

// File: tb/tb_px.sv
// tb_px: random request/ok stimulus checked clock-by-clock against a per-visit timing model.
// Directed visits cover idle cycling, fetch wait, priority, timeout and mid-pulse reset.
module tb_px;

    localparam int S1  = 3;
    localparam int S2  = 3;
    localparam int GAP = 2;
    localparam int TO  = 64;

    typedef enum int {
        B_P0, B_K1, B_K2, B_P1, B_P2, B_P3, B_P4, B_P5,
        B_I1, B_I2, B_I3, B_I4, B_I5, B_WX
    } st_e;

    // Pulse pattern {strob1_, strob2_, got_, mem_req} for each kind of clock.
    localparam logic [3:0] PL_S1  = 4'b0110;
    localparam logic [3:0] PL_GAP = 4'b1110;
    localparam logic [3:0] PL_MW  = 4'b1111;
    localparam logic [3:0] PL_S2  = 4'b1010;
    localparam logic [3:0] PL_GOT = 4'b1100;

    localparam st_e PRIO [14] = '{B_K2, B_K1, B_P0, B_I1, B_I2, B_I3, B_I4,
                                  B_I5, B_P1, B_P2, B_P3, B_P4, B_P5, B_WX};

    logic clk = 1'b0;
    logic clo;
    logic ok;
    logic [13:0] req;
    logic ep0, ep1, ep2, ep3, ep4, ep5, ek1, ek2, ei1, ei2, ei3, ei4, ei5, ewx;
    logic p0_, p1_, p2_, p3_, p4_, p5_, k1_, k2_, i1_, i2_, i3_, i4_, i5_, wx_;
    logic strob1_, strob2_, got_, mem_req, alarm;
    logic [13:0] lines;

    assign ep0 = req[B_P0];
    assign ep1 = req[B_P1];
    assign ep2 = req[B_P2];
    assign ep3 = req[B_P3];
    assign ep4 = req[B_P4];
    assign ep5 = req[B_P5];
    assign ek1 = req[B_K1];
    assign ek2 = req[B_K2];
    assign ei1 = req[B_I1];
    assign ei2 = req[B_I2];
    assign ei3 = req[B_I3];
    assign ei4 = req[B_I4];
    assign ei5 = req[B_I5];
    assign ewx = req[B_WX];

    assign lines = {p0_, k1_, k2_, p1_, p2_, p3_, p4_, p5_, i1_, i2_, i3_, i4_, i5_, wx_};

    px #(.S1_TICKS(S1), .S2_TICKS(S2), .GAP_TICKS(GAP), .OK_TIMEOUT(TO)) dut (
        .__clk(clk), .clo(clo),
        .ep0(ep0), .ep1(ep1), .ep2(ep2), .ep3(ep3), .ep4(ep4), .ep5(ep5),
        .ek1(ek1), .ek2(ek2),
        .ei1(ei1), .ei2(ei2), .ei3(ei3), .ei4(ei4), .ei5(ei5),
        .ewx(ewx), .ok(ok),
        .p0_(p0_), .p1_(p1_), .p2_(p2_), .p3_(p3_), .p4_(p4_), .p5_(p5_),
        .k1_(k1_), .k2_(k2_),
        .i1_(i1_), .i2_(i2_), .i3_(i3_), .i4_(i4_), .i5_(i5_), .wx_(wx_),
        .strob1_(strob1_), .strob2_(strob2_), .got_(got_),
        .mem_req(mem_req), .alarm(alarm)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   slots = 0;
    int   memreq_clocks = 0;
    int   p1_clocks = 0;
    st_e  cur = B_P0;
    logic alarm_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [13:0] onehot(st_e s);
        logic [13:0] r;
        r = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic [18:0] exp_vec(st_e s, logic [3:0] p, logic a);
        logic [13:0] low;
        low = 14'd1 << (13 - int'(s));
        return {~low, p, a};
    endfunction

    function automatic logic [18:0] obs_vec();
        return {lines, strob1_, strob2_, got_, mem_req, alarm};
    endfunction

    function automatic st_e next_state(st_e c, logic [13:0] r);
        for (int i = 0; i < 14; i++)
            if (r[PRIO[i]]) return PRIO[i];
        return c;
    endfunction

    function automatic logic [13:0] rand_req();
        logic [13:0] r;
        for (int i = 0; i < 14; i++) r[i] = ($urandom_range(0, 7) == 0);
        return r;
    endfunction

    function automatic bit is_two(st_e s);
        return s inside {B_P1, B_P3, B_P4, B_K2, B_I2, B_WX};
    endfunction

    function automatic bit is_mem(st_e s);
        return s inside {B_P1, B_P2, B_I2, B_I3, B_I4, B_I5};
    endfunction

    // One clock: wait for the edge, compare outputs, then drive inputs sampled on the next edge.
    task automatic do_slot(input logic [18:0] exp, input logic ok_v, input logic [13:0] req_v);
        @(posedge clk);
        #1;
        check("outputs", 32'(obs_vec()), 32'(exp));
        check("one_state_low", $countones(~lines), 1);
        check("strobe_excl", 32'((int'(!strob1_) + int'(!strob2_) + int'(!got_)) <= 1), 1);
        if (mem_req) memreq_clocks++;
        if (!p1_) p1_clocks++;
        ok  = ok_v;
        req = req_v;
        slots++;
    endtask

    task automatic mid_reset();
        #1;
        clo = 1'b1;
        #1;
        check("async_reset", 32'(obs_vec()), 32'(exp_vec(B_P0, 4'b1110, 1'b0)));
        req = '0;
        ok  = 1'b0;
        cur = B_P0;
        alarm_m = 1'b0;
        repeat (2) @(negedge clk);
        clo = 1'b0;
    endtask

    // w = 1..TO: ok arrives on the w-th MW clock; w = 0: ok never arrives (timeout).
    task automatic run_visit(input logic [13:0] go_req, input int w, input int abort_slot);
        logic [3:0] sched[$];
        logic [3:0] p;
        logic       ok_v;
        logic [13:0] r;
        int mw_idx;
        int mw_len;
        mw_idx = 0;
        mw_len = (w == 0) ? TO : w;
        repeat (S1)  sched.push_back(PL_S1);
        repeat (GAP) sched.push_back(PL_GAP);
        if (is_mem(cur)) repeat (mw_len) sched.push_back(PL_MW);
        if (is_two(cur)) begin
            repeat (S2)  sched.push_back(PL_S2);
            repeat (GAP) sched.push_back(PL_GAP);
        end
        sched.push_back(PL_GOT);
        for (int k = 0; k < sched.size(); k++) begin
            p    = sched[k];
            ok_v = 1'($urandom);
            r    = rand_req();
            if (p == PL_MW) begin
                ok_v = (w != 0 && mw_idx == w - 1);
                mw_idx++;
            end
            if (p == PL_GOT) r = go_req;
            do_slot(exp_vec(cur, p, alarm_m), ok_v, r);
            if (p == PL_MW && w == 0 && mw_idx == TO) alarm_m = 1'b1;
            if (k == abort_slot) begin
                mid_reset();
                return;
            end
        end
        cur = next_state(cur, go_req);
    endtask

    initial begin
        clo = 1'b1;
        req = '0;
        ok  = 1'b0;
        #3;
        check("reset_state", 32'(obs_vec()), 32'(exp_vec(B_P0, 4'b1110, 1'b0)));
        repeat (2) @(negedge clk);
        clo = 1'b0;

        // Idle cycling in P0, then fetch into P1.
        repeat (3) run_visit('0, 1, -1);
        run_visit(onehot(B_P1), 1, -1);

        // P1 with a 5-clock memory wait; on its GOT raise ep3, ei2, ek1 together.
        memreq_clocks = 0;
        p1_clocks = 0;
        run_visit(onehot(B_P3) | onehot(B_I2) | onehot(B_K1), 5, -1);
        check("fetch_memreq_clocks", memreq_clocks, 5);
        check("fetch_p1_clocks", p1_clocks, 16);

        // In K1, same requests minus ek1 -> I2; then I3 with a timeout, then WX.
        run_visit(onehot(B_P3) | onehot(B_I2), 1, -1);
        run_visit(onehot(B_I3), 3, -1);
        run_visit(onehot(B_P2), 0, -1);
        run_visit(onehot(B_WX), 2, -1);
        run_visit(onehot(B_P0), 1, S1 + GAP + 1);

        // Back in P0 after the reset; alarm must be clear again.
        run_visit('0, 1, -1);

        while (slots < 10000) begin
            int w;
            w = ($urandom_range(0, 31) == 0) ? 0 : int'($urandom_range(1, 8));
            run_visit(rand_req(), w, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
